sync_fifo_ctrl: RTL and testbench

Single-clock, parametrised FIFO with storage, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags. It is the same-clock successor to the dual-clock pointer block. It buffers feature-map and weight words between CNN pipeline stages that share one clock. Depth need not be a power of two. Read mode is either registered-output or first-word-fall-through, selected at compile time.

---
 rtl/sync_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with storage, occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for a first-word-fall-through read path; default is a registered read.
module sync_fifo_ctrl #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rest,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             rd_acc;
    logic             wr_acc;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    always_comb begin
        rd_acc = ~rest & rd_en & ~empty;
        wr_acc = ~rest & wr_en & (~full | rd_acc);
    end

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Occupancy and every status flag follow from the next count alone.
    always_ff @(posedge clk) begin
        if (rest) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            almost_empty <= 1'b1;
        end else begin
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (32'(count_nxt) >= AF_LEVEL);
            almost_empty <= (32'(count_nxt) <= AE_LEVEL);
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & ~wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented as soon as it lands; zero while nothing is stored.
    always_comb begin
        rd_data  = empty ? '0 : mem[rd_ptr];
        rd_valid = ~empty;
    end
`else
    always_ff @(posedge clk) begin
        if (rest) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: DEPTH=8 and DEPTH=6 instances share stimulus and are
// compared each cycle against a queue-based reference plus directed constant checks.
module tb_sync_fifo_ctrl;

    logic        clk;
    logic        rest;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] wr_data;

    logic [15:0] o_rdd [2];
    logic        o_rdv [2];
    logic        o_full [2];
    logic        o_empty [2];
    logic        o_af [2];
    logic        o_ae [2];
    logic        o_ovf [2];
    logic        o_unf [2];
    logic [3:0]  o_cnt [2];
    logic [3:0]  cnt8;
    logic [2:0]  cnt6;

    assign o_cnt[0] = cnt8;
    assign o_cnt[1] = {1'b0, cnt6};

    sync_fifo_ctrl #(.WIDTH(16), .DEPTH(8)) u_fifo8 (
        .clk(clk), .rest(rest), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(o_rdd[0]), .rd_valid(o_rdv[0]), .full(o_full[0]), .empty(o_empty[0]),
        .almost_full(o_af[0]), .almost_empty(o_ae[0]), .count(cnt8),
        .overflow(o_ovf[0]), .underflow(o_unf[0])
    );

    sync_fifo_ctrl #(.WIDTH(16), .DEPTH(6)) u_fifo6 (
        .clk(clk), .rest(rest), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(o_rdd[1]), .rd_valid(o_rdv[1]), .full(o_full[1]), .empty(o_empty[1]),
        .almost_full(o_af[1]), .almost_empty(o_ae[1]), .count(cnt6),
        .overflow(o_ovf[1]), .underflow(o_unf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue per FIFO plus sticky flags and read register.
    logic [15:0] mq [2][$];
    logic        m_ovf [2];
    logic        m_unf [2];
    logic        m_rdv [2];
    logic [15:0] m_rdd [2];

    int n_assert;
    int n_fail;
    int cyc;

    function automatic int depth_of(input int l);
        return (l == 0) ? 8 : 6;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input int l, input logic we, input logic re, input logic rs,
                              input logic [15:0] wd);
        bit rd_ok;
        bit wr_ok;
        if (rs) begin
            mq[l].delete();
            m_ovf[l] = 1'b0;
            m_unf[l] = 1'b0;
            m_rdv[l] = 1'b0;
            m_rdd[l] = '0;
            return;
        end
        rd_ok = re && (mq[l].size() != 0);
        wr_ok = we && ((mq[l].size() < depth_of(l)) || rd_ok);
        if (re && !rd_ok) m_unf[l] = 1'b1;
        if (we && !wr_ok) m_ovf[l] = 1'b1;
`ifndef SYNC_FIFO_FWFT_EN
        m_rdv[l] = rd_ok;
        if (rd_ok) m_rdd[l] = mq[l][0];
`endif
        if (rd_ok) void'(mq[l].pop_front());
        if (wr_ok) mq[l].push_back(wd);
    endtask

    task automatic check_lane(input int l);
        int sz;
        int d;
        sz = mq[l].size();
        d  = depth_of(l);
        chk($sformatf("L%0d count", l), 32'(o_cnt[l]), 32'(sz));
        chk($sformatf("L%0d full", l), 32'(o_full[l]), 32'(sz == d));
        chk($sformatf("L%0d empty", l), 32'(o_empty[l]), 32'(sz == 0));
        chk($sformatf("L%0d almost_full", l), 32'(o_af[l]), 32'(sz >= d - 2));
        chk($sformatf("L%0d almost_empty", l), 32'(o_ae[l]), 32'(sz <= 2));
        chk($sformatf("L%0d overflow", l), 32'(o_ovf[l]), 32'(m_ovf[l]));
        chk($sformatf("L%0d underflow", l), 32'(o_unf[l]), 32'(m_unf[l]));
`ifdef SYNC_FIFO_FWFT_EN
        chk($sformatf("L%0d rd_valid", l), 32'(o_rdv[l]), 32'(sz != 0));
        if (sz != 0) chk($sformatf("L%0d rd_data", l), 32'(o_rdd[l]), 32'(mq[l][0]));
`else
        chk($sformatf("L%0d rd_valid", l), 32'(o_rdv[l]), 32'(m_rdv[l]));
        chk($sformatf("L%0d rd_data", l), 32'(o_rdd[l]), 32'(m_rdd[l]));
`endif
    endtask

    // One clock: drive, edge, update model, then sample 1 time unit after the edge.
    task automatic step(input logic we, input logic re, input logic [15:0] wd, input logic rs);
        wr_en   = we;
        rd_en   = re;
        wr_data = wd;
        rest    = rs;
        @(posedge clk);
        for (int l = 0; l < 2; l++) model_step(l, we, re, rs, wd);
        #1;
        cyc++;
        for (int l = 0; l < 2; l++) check_lane(l);
    endtask

    initial begin
        logic [15:0] seq;
        int          pw;
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = '0;
        rest     = 1'b1;
        seq      = 16'h0100;

        // Reset state
        step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        chk("rst count", 32'(o_cnt[0]), 0);
        chk("rst empty", 32'(o_empty[0]), 1);
        chk("rst full", 32'(o_full[0]), 0);
        chk("rst almost_empty", 32'(o_ae[0]), 1);
        chk("rst almost_full", 32'(o_af[0]), 0);
        chk("rst rd_valid", 32'(o_rdv[0]), 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst rd_data", 32'(o_rdd[0]), 0);
`endif

        // Fill with 1..8; almost_full rises at count 6
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'(i + 1), 1'b0);
            chk("fill af8", 32'(o_af[0]), 32'(i + 1 >= 6));
        end
        chk("fill count8", 32'(o_cnt[0]), 8);
        chk("fill full8", 32'(o_full[0]), 1);
        chk("fill ovf8", 32'(o_ovf[0]), 0);
        chk("fill ovf6", 32'(o_ovf[1]), 1);
        step(1'b1, 1'b0, 16'h0009, 1'b0);
        chk("9th write ovf", 32'(o_ovf[0]), 1);
        chk("9th write count", 32'(o_cnt[0]), 8);

        // Drain in order; almost_empty rises at count 2
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 16'h0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
            chk("drain data", 32'(o_rdd[0]), 32'(i + 1));
`endif
            chk("drain ae8", 32'(o_ae[0]), 32'(8 - (i + 1) <= 2));
        end
        chk("drain empty", 32'(o_empty[0]), 1);
        chk("drain unf8 before", 32'(o_unf[0]), 0);
        step(1'b0, 1'b1, 16'h0, 1'b0);
        chk("9th read unf", 32'(o_unf[0]), 1);

        // Wrap: 20 bursts of four writes then four reads
        step(1'b0, 1'b0, 16'h0, 1'b1);
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b1, 1'b0, seq, 1'b0);
                seq++;
            end
            for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
        end
        chk("wrap ovf6", 32'(o_ovf[1]), 0);
        chk("wrap unf6", 32'(o_unf[1]), 0);

        // Full with simultaneous read and write for ten cycles
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, seq, 1'b0);
            seq++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, seq, 1'b0);
            seq++;
            chk("full rw count8", 32'(o_cnt[0]), 8);
            chk("full rw full8", 32'(o_full[0]), 1);
        end
        chk("full rw ovf8", 32'(o_ovf[0]), 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0, 1'b0);

        // Empty with simultaneous read and write
        step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b1, 1'b1, 16'hABCD, 1'b0);
        chk("empty rw count", 32'(o_cnt[0]), 1);
        chk("empty rw unf", 32'(o_unf[0]), 1);
`ifdef SYNC_FIFO_FWFT_EN
        chk("empty rw fwft data", 32'(o_rdd[0]), 32'h0000ABCD);
`endif
        step(1'b0, 1'b1, 16'h0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("empty rw readback", 32'(o_rdd[0]), 32'h0000ABCD);
`endif
        chk("empty rw drained", 32'(o_cnt[0]), 0);

        // Reset mid-operation at count 5, with a write in the reset cycle
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(16'h0200 + i), 1'b0);
        step(1'b0, 1'b1, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0205, 1'b0);
        chk("pre-rst count", 32'(o_cnt[0]), 5);
        step(1'b1, 1'b1, 16'hDEAD, 1'b1);
        chk("mid rst count", 32'(o_cnt[0]), 0);
        chk("mid rst empty", 32'(o_empty[0]), 1);
        chk("mid rst ovf", 32'(o_ovf[0]), 0);
        chk("mid rst unf", 32'(o_unf[0]), 0);
        chk("mid rst rd_valid", 32'(o_rdv[0]), 0);

        // Randomised traffic with drifting read/write bias and rare resets
        pw = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) pw = int'($urandom_range(15, 85));
            step(32'($urandom_range(0, 99)) < pw, 32'($urandom_range(0, 99)) >= pw,
                 16'($urandom), $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
